// File: rtl/wrr_stream_arbiter.sv
// ---------------------------------------------------------------------------
// wrr_stream_arbiter
//
// Weighted round-robin arbiter that shares one valid/ready stream sink
// between NUM_REQ packet sources. Whole packets are granted, as marked by the
// last flag, so beats of different packets are never interleaved. Requester k
// may send up to weight_i[k] consecutive packets per turn. A weight of 0 is
// treated as 1. The rotation looks ahead to the next valid requester, so
// back-to-back single-beat packets flow one per cycle with no bubble.
//
// Handshake: a beat transfers on a rising clk_i edge where valid && ready.
// A source holds valid and its payload stable until it is accepted, and
// ready never depends on a beat's payload.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   flush_i      synchronous clear of all arbiter state (wins over all else)
//   weight_i     packets per turn, slice k for requester k
//   req_valid_i  per-requester beat valid
//   req_data_i   per-requester payload, slice k
//   req_last_i   per-requester last-beat-of-packet flag
//   req_ready_o  per-requester ready (only the grantee can see ready)
//   gnt_valid_o  output beat valid
//   gnt_data_o   muxed payload of the grantee
//   gnt_last_o   muxed last flag of the grantee
//   gnt_idx_o    index of the current grantee
//   gnt_ready_i  sink ready
//   pkt_cnt_o    (only with WRR_ARB_PKT_CNT_EN) saturating per-requester
//                count of completed packets, 16 bits per slice
//
// Optional feature macro: WRR_ARB_PKT_CNT_EN
// ---------------------------------------------------------------------------
module wrr_stream_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic [NUM_REQ*WEIGHT_WIDTH-1:0]  weight_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_i,
  input  logic [NUM_REQ-1:0]               req_last_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  output logic                             gnt_valid_o,
  output logic [DATA_WIDTH-1:0]            gnt_data_o,
  output logic                             gnt_last_o,
  output logic [$clog2(NUM_REQ)-1:0]       gnt_idx_o,
  input  logic                             gnt_ready_i
`ifdef WRR_ARB_PKT_CNT_EN
  ,
  output logic [NUM_REQ*16-1:0]            pkt_cnt_o
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // All control state lives in one struct so it can be observed as a unit.
  typedef struct packed {
    state_e                  state;
    logic [IDX_W-1:0]        sel;     // locked / bursting grantee
    logic [IDX_W-1:0]        rr;      // requester whose turn is current/last
    logic [WEIGHT_WIDTH-1:0] credit;  // packets left in the current turn
    logic                    lock;    // offered beat stalled in IDLE
  } ctrl_t;

  // rr starts at NUM_REQ-1 so that index 0 is searched first.
  localparam ctrl_t CTRL_RST = '{
    state:  IDLE,
    sel:    '0,
    rr:     IDX_W'(NUM_REQ - 1),
    credit: '0,
    lock:   1'b0
  };

  ctrl_t                   ctrl_q;
  ctrl_t                   ctrl_d;
  logic [IDX_W-1:0]        sel;
  logic [IDX_W-1:0]        scan_idx;
  logic [IDX_W-1:0]        cand;
  logic                    scan_hit;
  logic                    hs;
  logic                    pkt_end;
  logic [WEIGHT_WIDTH-1:0] sel_weight;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q <= CTRL_RST;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  // -------------------------------------------------------------------------
  // Lookahead scan: first valid requester strictly after rr, wrapping, with
  // rr itself as the last candidate. Falls back to the stored grantee when
  // nothing is valid so the idle output mux stays put.
  // -------------------------------------------------------------------------
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = ctrl_q.sel;
    cand     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(ctrl_q.rr) + i) % NUM_REQ);
      if (!scan_hit && req_valid_i[cand]) begin
        scan_hit = 1'b1;
        scan_idx = cand;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output logic: grantee selection and the zero-latency stream mux.
  // -------------------------------------------------------------------------
  always_comb begin
    if (!rst_ni) begin
      sel = '0;
    end else if (ctrl_q.state == BURST || ctrl_q.lock) begin
      sel = ctrl_q.sel;
    end else if (ctrl_q.credit != '0 && req_valid_i[ctrl_q.rr]) begin
      // Current turn still has credit and its owner is offering a packet.
      sel = ctrl_q.rr;
    end else begin
      sel = scan_idx;
    end

    gnt_idx_o   = sel;
    gnt_data_o  = req_data_i[sel*DATA_WIDTH +: DATA_WIDTH];
    gnt_last_o  = req_last_i[sel];
    gnt_valid_o = rst_ni && req_valid_i[sel];

    // In BURST the grant is held even across source bubbles.
    req_ready_o = '0;
    if (rst_ni && gnt_ready_i &&
        (ctrl_q.state == BURST || req_valid_i[sel])) begin
      req_ready_o[sel] = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    ctrl_d     = ctrl_q;
    hs         = gnt_valid_o && gnt_ready_i;
    pkt_end    = hs && gnt_last_o;
    sel_weight = weight_i[sel*WEIGHT_WIDTH +: WEIGHT_WIDTH];

    if (flush_i) begin
      ctrl_d = CTRL_RST;
    end else begin
      unique case (ctrl_q.state)
        IDLE: begin
          if (hs) begin
            ctrl_d.lock = 1'b0;
            ctrl_d.sel  = sel;
            if (!gnt_last_o) begin
              ctrl_d.state = BURST;
            end
          end else if (gnt_valid_o) begin
            // Freeze the offered beat's owner until the sink takes it.
            ctrl_d.lock = 1'b1;
            ctrl_d.sel  = sel;
          end
        end
        BURST: begin
          if (pkt_end) begin
            ctrl_d.state = IDLE;
          end
        end
        default: ctrl_d = CTRL_RST;
      endcase

      // Packet-end accounting. A new turn reloads credit from the weight
      // sampled now, so weight changes only land at turn boundaries.
      if (pkt_end) begin
        if (sel != ctrl_q.rr || ctrl_q.credit == '0) begin
          ctrl_d.rr     = sel;
          ctrl_d.credit = (sel_weight == '0) ? '0 : sel_weight - 1'b1;
        end else begin
          ctrl_d.credit = ctrl_q.credit - 1'b1;
        end
      end
    end
  end

`ifdef WRR_ARB_PKT_CNT_EN
  // -------------------------------------------------------------------------
  // Completed-packet counters, saturating at 16'hFFFF.
  // -------------------------------------------------------------------------
  logic [NUM_REQ-1:0][15:0] pkt_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pkt_cnt_q <= '0;
    end else if (flush_i) begin
      pkt_cnt_q <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (pkt_end && sel == IDX_W'(k) && pkt_cnt_q[k] != 16'hFFFF) begin
          pkt_cnt_q[k] <= pkt_cnt_q[k] + 16'd1;
        end
      end
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_wrr_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wrr_stream_arbiter
//
// Directed bench for wrr_stream_arbiter. Per-requester source queues feed a
// driver; each test pushes its hand-ordered expected grant sequence into
// exp_q, and a monitor pops and compares on every sink handshake.
// ---------------------------------------------------------------------------
module tb_wrr_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int WW = 4;

  // Clock / reset / DUT signals
  logic              clk = 1'b0;
  logic              rst_ni;
  logic              flush_i;
  logic [N*WW-1:0]   weight_i;
  logic [N-1:0]      req_valid_i;
  logic [N*DW-1:0]   req_data_i;
  logic [N-1:0]      req_last_i;
  logic [N-1:0]      req_ready_o;
  logic              gnt_valid_o;
  logic [DW-1:0]     gnt_data_o;
  logic              gnt_last_o;
  logic [1:0]        gnt_idx_o;
  logic              gnt_ready_i;
`ifdef WRR_ARB_PKT_CNT_EN
  logic [N*16-1:0]   pkt_cnt_o;
`endif

  always #5 clk = ~clk;

  wrr_stream_arbiter #(
    .NUM_REQ      (N),
    .DATA_WIDTH   (DW),
    .WEIGHT_WIDTH (WW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .weight_i    (weight_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .gnt_valid_o (gnt_valid_o),
    .gnt_data_o  (gnt_data_o),
    .gnt_last_o  (gnt_last_o),
    .gnt_idx_o   (gnt_idx_o),
    .gnt_ready_i (gnt_ready_i)
`ifdef WRR_ARB_PKT_CNT_EN
    ,
    .pkt_cnt_o   (pkt_cnt_o)
`endif
  );

  // Scoreboard state: expected entry = {idx[1:0], last, data[31:0]}
  logic [34:0] exp_q[$];
  logic [32:0] src_q[N][$];      // per-requester beats {last, data}
  int          n_cmp      = 0;
  int          n_err      = 0;
  int          hs_count   = 0;
  int          ready_mode = 0;   // 0: always ready, 1: toggle, 2: stalled
  int          base;
  int          cnt_k[N];
  int          seq_w[12]      = '{0, 0, 0, 1, 2, 3, 0, 0, 0, 1, 2, 3};
  int          exp_pkt_cnt[N] = '{6, 2, 2, 2};

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  function automatic logic [31:0] mk(input int k, input int p, input int b);
    return {8'(k), 8'(p), 16'(b)};
  endfunction

  function automatic bit src_busy();
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic load_pkt(input int k, input int p, input int nb);
    for (int b = 0; b < nb; b++) begin
      src_q[k].push_back({(b == nb - 1), mk(k, p, b)});
    end
  endtask

  task automatic exp_beat(input int k, input int p, input int b, input logic last);
    exp_q.push_back({2'(k), last, mk(k, p, b)});
  endtask

  task automatic exp_pkt(input int k, input int p, input int nb);
    for (int b = 0; b < nb; b++) begin
      exp_beat(k, p, b, (b == nb - 1));
    end
  endtask

  task automatic drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || src_busy()) && n < max_cyc) begin
      step();
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || src_busy()) begin
      n_err++;
      $display("FAIL %s: drain timeout, %0d beats still expected", name, exp_q.size());
      exp_q.delete();
      for (int k = 0; k < N; k++) src_q[k].delete();
    end
  endtask

  task automatic do_flush();
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Driver: samples accepts at negedge, advances sources after posedge.
  // -------------------------------------------------------------------------
  initial begin
    logic [N-1:0] acc;
    logic         tog;
    tog         = 1'b0;
    req_valid_i = '0;
    req_last_i  = '0;
    gnt_ready_i = 1'b0;
    for (int k = 0; k < N; k++) req_data_i[k*DW +: DW] = 32'hD000_0000 | 32'(k);
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) acc[k] = req_valid_i[k] && req_ready_o[k];
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (acc[k] && src_q[k].size() != 0) void'(src_q[k].pop_front());
        if (src_q[k].size() != 0) begin
          req_valid_i[k]          = 1'b1;
          req_last_i[k]           = src_q[k][0][32];
          req_data_i[k*DW +: DW]  = src_q[k][0][31:0];
        end else begin
          req_valid_i[k]          = 1'b0;
          req_last_i[k]           = 1'b0;
          req_data_i[k*DW +: DW]  = 32'hD000_0000 | 32'(k);
        end
      end
      tog = ~tog;
      case (ready_mode)
        0:       gnt_ready_i = 1'b1;
        1:       gnt_ready_i = tog;
        default: gnt_ready_i = 1'b0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Monitor: compares every sink handshake against the expected queue.
  // -------------------------------------------------------------------------
  initial begin
    logic [34:0]  e;
    logic [N-1:0] want_rdy;
    forever begin
      @(negedge clk);
      if (rst_ni && gnt_valid_o && gnt_ready_i) begin
        hs_count++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL beat: unexpected idx=%0d last=%0d data=%h",
                   gnt_idx_o, gnt_last_o, gnt_data_o);
        end else begin
          e        = exp_q.pop_front();
          want_rdy = N'(1) << e[34:33];
          if ({gnt_idx_o, gnt_last_o, gnt_data_o} !== e || req_ready_o !== want_rdy) begin
            n_err++;
            $display("FAIL beat: got idx=%0d last=%0d data=%h ready=%b, expected idx=%0d last=%0d data=%h ready=%b",
                     gnt_idx_o, gnt_last_o, gnt_data_o, req_ready_o,
                     e[34:33], e[32], e[31:0], want_rdy);
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Directed tests
  // -------------------------------------------------------------------------
  initial begin
    rst_ni   = 1'b0;
    flush_i  = 1'b0;
    weight_i = {4'd1, 4'd1, 4'd1, 4'd1};

    // Reset values
    repeat (3) @(negedge clk);
    #2;
    check("rst_gnt_valid", 64'(gnt_valid_o), 64'd0);
    check("rst_req_ready", 64'(req_ready_o), 64'd0);
    check("rst_gnt_idx", 64'(gnt_idx_o), 64'd0);
    check("rst_gnt_data", 64'(gnt_data_o), 64'hD000_0000);
    check("rst_gnt_last", 64'(gnt_last_o), 64'd0);
`ifdef WRR_ARB_PKT_CNT_EN
    check("rst_pkt_cnt", 64'(pkt_cnt_o), 64'd0);
`endif
    rst_ni = 1'b1;

    // Basic rotation: weights 1, continuous single-beat packets
    step();
    base = hs_count;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < N; k++) begin
        load_pkt(k, p, 1);
        exp_pkt(k, p, 1);
      end
    end
    repeat (12) step();
    check("rotation_no_bubble", 64'(hs_count - base), 64'd12);
    drain("rotation", 20);

    // Weights {3,1,0,1} for requesters 0..3; weight 0 acts as 1
    weight_i = {4'd1, 4'd0, 4'd1, 4'd3};
    do_flush();
    step();
    for (int p = 0; p < 6; p++) load_pkt(0, p, 1);
    for (int k = 1; k < N; k++) begin
      for (int p = 0; p < 2; p++) load_pkt(k, p, 1);
    end
    for (int k = 0; k < N; k++) cnt_k[k] = 0;
    for (int i = 0; i < 12; i++) begin
      exp_pkt(seq_w[i], cnt_k[seq_w[i]], 1);
      cnt_k[seq_w[i]]++;
    end
    drain("weights", 30);
`ifdef WRR_ARB_PKT_CNT_EN
    for (int k = 0; k < N; k++) begin
      check("pkt_cnt_weights", 64'(pkt_cnt_o[k*16 +: 16]), 64'(exp_pkt_cnt[k]));
    end
`endif
    weight_i = {4'd1, 4'd1, 4'd1, 4'd1};

    // Packet atomicity with a toggling sink
    do_flush();
    ready_mode = 1;
    step();
    load_pkt(0, 0, 4);
    load_pkt(1, 0, 2);
    exp_pkt(0, 0, 4);
    exp_pkt(1, 0, 2);
    drain("atomicity", 40);
    ready_mode = 0;

    // Stall lock: req2 stalled, req0 joins, grant must not move
    do_flush();
    ready_mode = 2;
    step();
    load_pkt(2, 0, 1);
    exp_pkt(2, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("lock_valid", 64'(gnt_valid_o), 64'd1);
      check("lock_idx", 64'(gnt_idx_o), 64'd2);
      check("lock_data", 64'(gnt_data_o), 64'(mk(2, 0, 0)));
      if (i == 1) begin
        load_pkt(0, 0, 1);
        exp_pkt(0, 0, 1);
      end
    end
    ready_mode = 0;
    drain("lock", 20);

    // Lookahead: rr=1, only req3 -> same-cycle grant; then wrap to 0
    do_flush();
    step();
    load_pkt(1, 0, 1);
    exp_pkt(1, 0, 1);
    drain("lookahead_setup", 10);
    step();
    base = hs_count;
    load_pkt(3, 0, 1);
    exp_pkt(3, 0, 1);
    step();
    check("lookahead_latency", 64'(hs_count - base), 64'd1);
    drain("lookahead_3", 10);
    step();
    load_pkt(0, 0, 1);
    exp_pkt(0, 0, 1);
    drain("lookahead_wrap", 10);

    // Flush mid-burst of req1; req0 valid on the following cycle
    do_flush();
    step();
    load_pkt(1, 0, 4);
    exp_beat(1, 0, 0, 1'b0);
    exp_beat(1, 0, 1, 1'b0);
    step();
    step();
    flush_i = 1'b1;
    src_q[1].delete();
    load_pkt(0, 1, 1);
    exp_pkt(0, 1, 1);
    step();
    flush_i = 1'b0;
    drain("flush_mid_burst", 10);

    // Asynchronous reset mid-burst
    step();
    load_pkt(1, 1, 3);
    exp_beat(1, 1, 0, 1'b0);
    step();
    rst_ni = 1'b0;
    #1;
    check("async_rst_gnt_valid", 64'(gnt_valid_o), 64'd0);
    check("async_rst_req_ready", 64'(req_ready_o), 64'd0);
    check("async_rst_gnt_idx", 64'(gnt_idx_o), 64'd0);
    for (int k = 0; k < N; k++) src_q[k].delete();
    step();
    step();
`ifdef WRR_ARB_PKT_CNT_EN
    check("async_rst_pkt_cnt", 64'(pkt_cnt_o), 64'd0);
`endif
    rst_ni = 1'b1;
    step();
    load_pkt(2, 1, 1);
    exp_pkt(2, 1, 1);
    drain("post_reset", 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wrr_stream_arbiter.md
Name: wrr_stream_arbiter

Overview:
- Weighted round-robin arbiter that shares one valid/ready stream sink between NUM_REQ packet sources.
- Grants whole packets, delimited by a last flag, and never interleaves beats of different packets.
- Each requester may send up to weight_i[k] consecutive packets before the grant rotates to the next valid requester; the rotation uses lookahead.
- Sits in front of shared resources such as memory ports and interconnect links, where a plain per-beat round-robin arbiter would split packets.

Parameters:
- NUM_REQ, 4: number of requesters; must be ≥ 2.
- DATA_WIDTH, 32: payload width per beat.
- WEIGHT_WIDTH, 4: width of each per-requester weight.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous clear of all state.
- weight_i  in  NUM_REQ*WEIGHT_WIDTH  packets per turn for requester k, in slice k.
- req_valid_i  in  NUM_REQ  requester beat valid.
- req_data_i  in  NUM_REQ*DATA_WIDTH  requester payload, slice k.
- req_last_i  in  NUM_REQ  last beat of packet.
- req_ready_o  out  NUM_REQ  requester beat accepted when valid&ready.
- gnt_valid_o  out  1  output beat valid.
- gnt_data_o  out  DATA_WIDTH  muxed payload.
- gnt_last_o  out  1  muxed last flag.
- gnt_idx_o  out  $clog2(NUM_REQ)  index of current grantee.
- gnt_ready_i  in  1  sink ready.

Behaviour:
- Registers: state_q (IDLE/BURST), sel_q (grantee), rr_q (last served index), credit_q (WEIGHT_WIDTH), lock_q.
- Reset and flush values: state_q=IDLE, rr_q=NUM_REQ-1 (so index 0 is searched first), sel_q=0, credit_q=0, lock_q=0.
- Reset output values: gnt_valid_o=0, req_ready_o=0, gnt_idx_o=0, gnt_data_o=req_data_i[0] slice, gnt_last_o=req_last_i[0].
- Flush takes priority over every other event in the same cycle.
- Output path is combinational, zero latency: gnt_valid_o=req_valid_i[sel]; gnt_data_o and gnt_last_o are slice sel; req_ready_o[k]=gnt_ready_i && (k==sel) && grant active; gnt_idx_o=sel.

IDLE state:
- If lock_q=0: sel = first valid index strictly after rr_q, wrapping modulo NUM_REQ. If credit_q>0 and req_valid_i[rr_q]=1, sel=rr_q instead (continuation of the current turn).
- If no request is valid: gnt_valid_o=0 and all state is held.
- Valid but not ready: set lock_q=1 and store sel in sel_q. While locked, sel=sel_q regardless of other requests; output stays stable until handshake.
- Handshake with last=0: go to BURST with sel_q=sel, clear lock_q.
- Handshake with last=1: packet ends; stay in IDLE and apply packet-end accounting.

BURST state:
- sel=sel_q, fixed. Other requesters get ready=0.
- A requester dropping valid mid-packet produces bubbles only; the grant is held.
- Handshake with last=1: return to IDLE and apply packet-end accounting.

Packet-end accounting:
- If sel differs from rr_q, or credit_q==0 (new turn): credit_q = max(weight_i[sel],1) - 1, and rr_q=sel.
- Otherwise credit_q = credit_q - 1.
- Weight 0 is treated as 1. Weight changes take effect at the next turn start only.
- Single-beat packets (last=1 on the first beat) never enter BURST.
- Back-to-back single-beat packets can be granted every cycle with no bubble.

Optional Feature:
- Macro WRR_ARB_PKT_CNT_EN.
- Defined: adds output pkt_cnt_o [NUM_REQ*16]. Slice k is a per-requester count of completed packets, saturating at 16'hFFFF. It is reset and flushed to 0 and increments on every handshake with last=1 while sel==k.
- Undefined: the port and counters do not exist; all other behaviour is identical.

Test Plan:
- Basic rotation: weights all 1, all four requesters send continuous single-beat packets, gnt_ready_i=1 → gnt_idx_o sequence 0,1,2,3,0,… with one beat per cycle and no bubbles.
- Weights: weights {3,1,1,1}, all requesters valid with single-beat packets → idx sequence 0,0,0,1,2,3,0,0,0,…; weight 0 on requester 2 behaves as 1.
- Packet atomicity: req0 sends a 4-beat packet while req1 is valid; gnt_ready_i toggles 1,0,1,0… → all 4 beats of req0 appear before any req1 beat; req1 ready stays 0 throughout; the first req1 beat follows the req0 last beat.
- Stall lock: req2 valid with gnt_ready_i=0 for 5 cycles, then req0 asserts valid → gnt_idx_o stays 2 and gnt_data_o stays stable until ready=1; the next grant goes to 0.
- Lookahead: rr_q=1, only req3 valid → grant goes to 3 in the same cycle. Then only req0 valid → grant wraps to 0.
- Flush and reset mid-operation: flush_i asserted mid-burst of req1, with req0 valid on the following cycle → state returns to IDLE and the next grant goes to 0. Asserting rst_ni=0 mid-burst drives gnt_valid_o=0 immediately; with WRR_ARB_PKT_CNT_EN defined, pkt_cnt_o reads 0 afterwards.
